// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads (2x scaled, with a one-entry
// reuse cache) take absolute priority, host reads/writes fill the idle cycles.
`timescale 1ns/1ps
module vga_fb_arbiter #(
  parameter int FB_W = 320,
  parameter int FB_H = 240,
  parameter int AW   = 17
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [9:0]    disp_x,
  input  logic [9:0]    disp_y,
  output logic [7:0]    color_out,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic [15:0]   stall_cnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_ACK   = 1'b1;
  localparam logic [10:0] DISP_W  = 11'(2 * FB_W);
  localparam logic [10:0] DISP_H  = 11'(2 * FB_H);
  localparam logic [AW:0] FB_SIZE = (AW+1)'(FB_W * FB_H);

  logic [0:0]    state;
  logic          rd_op, rd_pend;
  logic [7:0]    rdata_q;
  logic          last_valid;
  logic [AW-1:0] last_addr;
  logic [7:0]    pix_q;
  logic          sel_miss, sel_hit;

  logic [AW-1:0] y_h, x_h, disp_addr;
  logic          disp_valid, disp_hit, disp_miss;
  logic          host_in, host_idle_req, host_grant;

  // y*320 as y*256 + y*64, so no multiplier on the pixel path
  assign y_h        = AW'(disp_y[9:1]);
  assign x_h        = AW'(disp_x[9:1]);
  assign disp_addr  = (y_h << 8) + (y_h << 6) + x_h;

  assign disp_valid = disp_req && ({1'b0, disp_x} < DISP_W) && ({1'b0, disp_y} < DISP_H);
  assign disp_hit   = disp_valid && last_valid && (disp_addr == last_addr);
  assign disp_miss  = disp_valid && !disp_hit;

  assign host_in       = {1'b0, host_addr} < FB_SIZE;
  assign host_idle_req = (state == S_IDLE) && host_req;
  assign host_grant    = host_idle_req && !disp_miss;

  assign mem_en    = reset && (disp_miss || (host_grant && host_in));
  assign mem_we    = reset && host_grant && host_in && host_we;
  assign mem_addr  = disp_miss ? disp_addr : host_addr;
  assign mem_wdata = host_wdata;

  assign color_out  = sel_miss ? mem_rdata : (sel_hit ? pix_q : 8'h00);
  assign host_ack   = (state == S_ACK);
  // out-of-range reads never touch the RAM and return 0
  assign host_rdata = (host_ack && rd_op) ? (rd_pend ? mem_rdata : 8'h00) : rdata_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      rd_op      <= 1'b0;
      rd_pend    <= 1'b0;
      rdata_q    <= 8'h00;
      last_valid <= 1'b0;
      last_addr  <= '0;
      pix_q      <= 8'h00;
      sel_miss   <= 1'b0;
      sel_hit    <= 1'b0;
      stall_cnt  <= 16'h0000;
    end else begin
      sel_miss <= disp_miss;
      sel_hit  <= disp_hit;
      if (sel_miss)
        pix_q <= mem_rdata;

      // a host write to the cached pixel would leave pix_q stale
      if (disp_miss) begin
        last_addr  <= disp_addr;
        last_valid <= 1'b1;
      end else if (host_grant && host_we && (host_addr == last_addr)) begin
        last_valid <= 1'b0;
      end

      state   <= host_grant ? S_ACK : S_IDLE;
      rd_op   <= host_grant && !host_we;
      rd_pend <= host_grant && !host_we && host_in;
      if (host_ack && rd_op)
        rdata_q <= host_rdata;

      if (host_idle_req && disp_miss && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, vector table, directed corner sequences
// and a random phase checked by a frame-buffer-level reference model.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  localparam int FB_W = 320, FB_H = 240, AW = 17;
  localparam int FB_SIZE = FB_W * FB_H;

  logic          clock = 1'b0, reset = 1'b0;
  logic          disp_req = 1'b0;
  logic [9:0]    disp_x = '0, disp_y = '0;
  logic [7:0]    color_out;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic          host_ack;
  logic [7:0]    host_rdata;
  logic [15:0]   stall_cnt;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;

  vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y), .color_out(color_out),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .stall_cnt(stall_cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #20 clock = ~clock;

  logic [7:0] ram [0:(1<<AW)-1];
  logic [7:0] fb  [0:FB_SIZE-1];

  always @(posedge clock)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) ^ (i >> 7) ^ 8'h5A);
  endfunction

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame buffer as an array plus the cache rule
  bit         live = 1'b0;
  logic [7:0] e_color, e_hrd;
  bit         e_ack, cv;
  int         e_stall, ca;
  int         m_a;
  bit         m_dv, m_miss, m_g, m_hin;

  always @(negedge clock) begin
    if (live) begin
      chk("color_out", 32'(color_out), 32'(e_color));
      chk("host_ack", 32'(host_ack), 32'(e_ack));
      chk("host_rdata", 32'(host_rdata), 32'(e_hrd));
      chk("stall_cnt", 32'(stall_cnt), 32'(e_stall));
    end
    if (!reset) begin
      chk("mem_en_in_reset", 32'(mem_en), 32'(0));
      chk("mem_we_in_reset", 32'(mem_we), 32'(0));
      live = 1'b1; e_color = 8'h00; e_hrd = 8'h00; e_ack = 1'b0;
      e_stall = 0; cv = 1'b0; ca = 0;
    end else if (live) begin
      m_dv   = disp_req && (int'(disp_x) < 2*FB_W) && (int'(disp_y) < 2*FB_H);
      m_a    = (int'(disp_y) / 2) * FB_W + int'(disp_x) / 2;
      m_miss = m_dv && !(cv && ca == m_a);
      m_g    = host_req && !e_ack && !m_miss;
      m_hin  = int'(host_addr) < FB_SIZE;
      chk("mem_en", 32'(mem_en), 32'(m_miss || (m_g && m_hin)));
      if (m_miss) begin
        chk("mem_addr_disp", 32'(mem_addr), 32'(m_a));
        chk("mem_we_disp", 32'(mem_we), 32'(0));
      end else if (m_g && m_hin) begin
        chk("mem_addr_host", 32'(mem_addr), 32'(host_addr));
        chk("mem_we_host", 32'(mem_we), 32'(host_we));
        if (host_we) chk("mem_wdata", 32'(mem_wdata), 32'(host_wdata));
      end
      if (host_req && !e_ack && m_miss && e_stall < 65535) e_stall++;
      e_color = m_dv ? fb[m_a] : 8'h00;
      if (m_miss) begin cv = 1'b1; ca = m_a; end
      if (m_g) begin
        if (!host_we) e_hrd = m_hin ? fb[host_addr] : 8'h00;
        else if (m_hin) begin
          fb[host_addr] = host_wdata;
          if (cv && ca == int'(host_addr)) cv = 1'b0;
        end
      end
      e_ack = m_g;
    end
  end

  task automatic drv(input bit dr, input int x, input int y,
                     input bit hr, input bit we, input int ad, input int wd);
    disp_req = dr; disp_x = 10'(x); disp_y = 10'(y);
    host_req = hr; host_we = we; host_addr = AW'(ad); host_wdata = 8'(wd);
  endtask

  task automatic nxt;
    @(posedge clock); #1;
  endtask

  typedef struct {
    bit dr; int x, y; bit hr, we; int ad, wd;
    bit e_en; int e_addr; int e_color; bit e_ack, e_rd; int e_rdata;
  } vec_t;
  vec_t tv [14];

  int sx, sy, ack_cyc, r;
  logic [7:0] p_color;
  bit p_ack, p_rd;
  int p_rdata;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = pat(i);
    for (int i = 0; i < FB_SIZE; i++) fb[i] = pat(i);

    tv[0]  = '{1,   0, 0, 0, 0,     0,   0, 1,   0, pat(0), 0, 0, 0};
    tv[1]  = '{1,   1, 0, 0, 0,     0,   0, 0,   0, pat(0), 0, 0, 0};
    tv[2]  = '{1,   2, 0, 0, 0,     0,   0, 1,   1, pat(1), 0, 0, 0};
    tv[3]  = '{1,   3, 0, 0, 0,     0,   0, 0,   0, pat(1), 0, 0, 0};
    tv[4]  = '{0,   0, 0, 1, 1,   321, 'hA5, 1, 321, 0,     1, 0, 0};
    tv[5]  = '{0,   0, 0, 0, 0,     0,   0, 0,   0, 0,      0, 0, 0};
    tv[6]  = '{1,   2, 2, 0, 0,     0,   0, 1, 321, 'hA5,   0, 0, 0};
    tv[7]  = '{0,   0, 0, 1, 0,   321,   0, 1, 321, 0,      1, 1, 'hA5};
    tv[8]  = '{0,   0, 0, 0, 0,     0,   0, 0,   0, 0,      0, 0, 0};
    tv[9]  = '{1, 640, 0, 0, 0,     0,   0, 0,   0, 0,      0, 0, 0};
    tv[10] = '{0,   0, 0, 1, 1, 76800, 'h77, 0,  0, 0,      1, 0, 0};
    tv[11] = '{0,   0, 0, 0, 0,     0,   0, 0,   0, 0,      0, 0, 0};
    tv[12] = '{0,   0, 0, 1, 0, 76800,   0, 0,   0, 0,      1, 1, 0};
    tv[13] = '{0,   0, 0, 0, 0,     0,   0, 0,   0, 0,      0, 0, 0};

    // reset
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_host_ack", 32'(host_ack), 32'(0));
    chk("rst_host_rdata", 32'(host_rdata), 32'(0));
    chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));
    chk("rst_color_out", 32'(color_out), 32'(0));
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    nxt;

    // vector table
    p_color = 8'h00; p_ack = 1'b0; p_rd = 1'b0; p_rdata = 0;
    for (int i = 0; i < 14; i++) begin
      drv(tv[i].dr, tv[i].x, tv[i].y, tv[i].hr, tv[i].we, tv[i].ad, tv[i].wd);
      @(negedge clock);
      chk($sformatf("tv%0d_mem_en", i), 32'(mem_en), 32'(tv[i].e_en));
      if (tv[i].e_en) begin
        chk($sformatf("tv%0d_mem_addr", i), 32'(mem_addr), 32'(tv[i].e_addr));
        chk($sformatf("tv%0d_mem_we", i), 32'(mem_we), 32'(tv[i].hr && tv[i].we));
      end
      chk($sformatf("tv%0d_color", i), 32'(color_out), 32'(p_color));
      chk($sformatf("tv%0d_ack", i), 32'(host_ack), 32'(p_ack));
      if (p_ack && p_rd) chk($sformatf("tv%0d_rdata", i), 32'(host_rdata), 32'(p_rdata));
      p_color = 8'(tv[i].e_color); p_ack = tv[i].e_ack; p_rd = tv[i].e_rd; p_rdata = tv[i].e_rdata;
      nxt;
    end

    // streaming x=0..15 with a held host read
    ack_cyc = -1;
    for (int x = 0; x < 16; x++) begin
      drv(1, x, 0, ack_cyc < 0, 0, 100, 0);
      @(negedge clock);
      if (host_ack && ack_cyc < 0) ack_cyc = x;
      nxt;
    end
    chk("stream_ack_le3", 32'(ack_cyc >= 1 && ack_cyc <= 3), 32'(1));
    chk("stream_stall", 32'(stall_cnt), 32'(1));

    // coherency: hit on 5, host writes 5, next request re-reads RAM
    drv(1, 10, 0, 0, 0, 0, 0); nxt;
    drv(1, 11, 0, 0, 0, 0, 0);
    @(negedge clock); chk("coh_hit_no_mem", 32'(mem_en), 32'(0)); nxt;
    drv(0, 0, 0, 1, 1, 5, 'h3C); nxt;
    drv(0, 0, 0, 0, 0, 0, 0); nxt;
    drv(1, 10, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("coh_remiss_en", 32'(mem_en), 32'(1));
    chk("coh_remiss_addr", 32'(mem_addr), 32'(5));
    nxt;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("coh_color", 32'(color_out), 32'(8'h3C)); nxt;

    // random phase
    sx = 0; sy = 0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        sx++;
        if (sx == 640) begin sx = 0; sy = (sy + 1) % 480; end
        disp_req = 1'b1; disp_x = 10'(sx); disp_y = 10'(sy);
      end else if (r == 7) begin
        disp_req = 1'b0;
      end else if (r == 8) begin
        disp_req = 1'b1; disp_x = 10'($urandom_range(0, 639)); disp_y = 10'($urandom_range(0, 479));
      end else begin
        disp_req = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          disp_x = 10'($urandom_range(640, 1023)); disp_y = 10'($urandom_range(0, 1023));
        end else begin
          disp_x = 10'($urandom_range(0, 1023)); disp_y = 10'($urandom_range(480, 1023));
        end
      end
      if ((!host_req && $urandom_range(0, 9) < 4) || (host_req && e_ack && $urandom_range(0, 1) == 1)) begin
        host_req   = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_wdata = 8'($urandom);
        r = $urandom_range(0, 9);
        if (r < 2)      host_addr = AW'($urandom_range(FB_SIZE, (1 << AW) - 1));
        else if (r < 6) host_addr = AW'((sy / 2) * FB_W + sx / 2 + $urandom_range(0, 1));
        else            host_addr = AW'($urandom_range(0, FB_SIZE - 1));
      end else if (host_req && e_ack) begin
        host_req = 1'b0;
      end
      nxt;
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (3) nxt;

    // continuous display misses saturate stall_cnt
    for (int k = 0; k < 65541; k++) begin
      drv(1, (2 * k) % 640, 0, k > 0, 0, 50, 0);
      nxt;
    end
    @(negedge clock);
    chk("stall_saturated", 32'(stall_cnt), 32'(16'hFFFF));

    // grant, then reset during the ack with a display request pending
    drv(0, 0, 0, 1, 0, 50, 0); nxt;
    drv(1, 100, 0, 0, 0, 0, 0); reset = 1'b0;
    @(negedge clock);
    chk("ack_before_reset", 32'(host_ack), 32'(1));
    chk("stall_before_reset", 32'(stall_cnt), 32'(16'hFFFF));
    chk("mem_en_reset_low", 32'(mem_en), 32'(0));
    nxt;
    reset = 1'b1; drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("post_rst_ack", 32'(host_ack), 32'(0));
    chk("post_rst_rdata", 32'(host_rdata), 32'(0));
    chk("post_rst_stall", 32'(stall_cnt), 32'(0));
    chk("post_rst_color", 32'(color_out), 32'(0));
    nxt;
    repeat (2) nxt;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
